spi_slave_ctrl: RTL and testbench
=================================

SPI_SLAVE_CTRL -- requirements
Module: spi_slave_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: sys_clk and rst_b; all logic on posedge sys_clk, cleared on negedge rst_b.
REQ-002 Ports, in this order (name, direction, width, meaning):
  sys_clk  in  1  system clock
  rst_b  in  1  async active-low reset
  spi_sclk  in  1  external SPI clock, asynchronous to sys_clk
  spi_cs_n  in  1  external chip select, active low
  spi_mosi  in  1  serial data from the external master
  spi_miso  out  1  serial data to the external master
  spi_miso_oe  out  1  pad output enable for spi_miso
  reg_ctrl_en  in  1  block enable from the register block
  reg_ctrl_bc  in  3  frame length in bytes minus 1 (N = 8*(bc+1) bits)
  reg_ctrl_tx_data  in  64  response data; bits [N-1:0] are sent
  ctrl_reg_rx_data  out  64  last received frame, right-aligned, zero-extended
  ctrl_reg_rd_en  out  1  one-cycle pulse: rx_data valid
  ctrl_reg_busy  out  1  frame in progress
  ctrl_reg_abort  out  1  one-cycle pulse: frame cut short by CS deassert
REQ-003 SHALL use one parameter: SYNC_STAGES, default 2, the synchronizer depth on spi_sclk, spi_cs_n and spi_mosi.

Function
REQ-004 SHALL implement SPI mode 0, MSB first: sample MOSI on SCLK rising edge; update MISO on SCLK falling edge.
REQ-005 SHALL synchronize the three SPI inputs through SYNC_STAGES flops and detect edges against one further history flop; a pin edge takes effect SYNC_STAGES+1 sys_clk cycles later.
REQ-006 SHALL require f(sys_clk) >= 8 * f(spi_sclk); operation at lower ratios is undefined.
REQ-007 SHALL have three states: IDLE, SHIFT and DONE.
REQ-008 IDLE -> SHIFT on a synced falling edge of cs_n while reg_ctrl_en=1; in the same cycle SHALL:
  latch bc into frame_len;
  load the tx shifter with reg_ctrl_tx_data[N-1:0] left-aligned;
  clear bit_cnt.
REQ-009 While in SHIFT, on a synced SCLK rise SHALL shift synced MOSI into the rx shifter and increment a 7-bit bit_cnt.
REQ-010 While in SHIFT, on a synced SCLK fall SHALL shift the tx shifter left by one; spi_miso always equals the tx shifter MSB.
REQ-011 SHIFT -> DONE when bit_cnt reaches N on a rising edge.
REQ-012 DONE (exactly 1 cycle) SHALL:
  update ctrl_reg_rx_data;
  pulse ctrl_reg_rd_en;
  reload the tx shifter and frame_len from the current inputs;
  clear bit_cnt;
  go to SHIFT if synced cs_n=0, otherwise to IDLE.
REQ-013 Synced cs_n rise while in SHIFT with 0 < bit_cnt < N SHALL pulse ctrl_reg_abort, leave ctrl_reg_rx_data unchanged and return to IDLE; with bit_cnt=0 it SHALL return to IDLE silently.
REQ-014 spi_miso_oe SHALL be 1 only in SHIFT/DONE with synced cs_n=0; spi_miso SHALL be 0 when spi_miso_oe=0.
REQ-015 ctrl_reg_busy SHALL be 1 in SHIFT and DONE, 0 in IDLE.
REQ-016 reg_ctrl_en=0 SHALL force IDLE next cycle, from any state, with no rd_en or abort pulse.
REQ-017 Changes to reg_ctrl_tx_data or reg_ctrl_bc during a frame SHALL NOT affect that frame.
REQ-018 When SCLK rise and CS rise are detected in the same cycle, the CS rise SHALL take priority.

Reset
REQ-019 On rst_b low SHALL set the FSM to IDLE, all shifters and bit_cnt to 0, and every synchronizer flop for spi_cs_n to 1 and for spi_sclk and spi_mosi to 0.
REQ-020 During reset, outputs SHALL read: spi_miso=0, spi_miso_oe=0, ctrl_reg_rx_data=0, ctrl_reg_rd_en=0, ctrl_reg_busy=0, ctrl_reg_abort=0.
REQ-021 Reset mid-frame SHALL discard the frame without any pulse; the next frame requires a fresh cs_n fall.

Structure
REQ-022 The state encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the bit-length function N=8*(bc+1) SHALL live in a shared SPI package used by both the master and the slave.
REQ-023 The input synchronizer SHALL be one sub-module, spi_sync_edge (SYNC_STAGES flops plus a history flop), outputting level, rise and fall; it is instantiated three times.

Verification
REQ-024 Single 8-bit frame: bc=0, tx_data=0xA5, master sends 0x3C -> MISO bit sequence 1010_0101; after the 8th rise, one rd_en pulse with rx_data=0x0000_0000_0000_003C.
REQ-025 Full 64-bit frame: bc=7, tx=0x0123_4567_89AB_CDEF, master sends 0xFEDC_BA98_7654_3210 -> MISO matches tx MSB first; rx_data=0xFEDC_BA98_7654_3210; busy high throughout.
REQ-026 Back-to-back frames: bc=1, CS held low for 32 SCLKs, tx_data changed to 0xBEEF after the first frame -> two rd_en pulses; second MISO word is 0xBEEF.
REQ-027 Abort: bc=3, CS raised after 13 SCLK rises -> one abort pulse, no rd_en, rx_data unchanged, state IDLE, miso_oe=0.
REQ-028 Enable/reset mid-frame: reg_ctrl_en dropped after 4 bits, then rst_b pulsed after 4 bits of a new frame -> IDLE, no pulses, all outputs at reset values.

Source files
------------

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI state encoding and frame-length helpers
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } spi_state_e;

    function automatic logic [6:0] frame_bits(input logic [2:0] bc);
        return {({1'b0, bc} + 4'd1), 3'b000};
    endfunction

    // Left-align the N response bits so the first bit out is always bit 63.
    function automatic logic [63:0] tx_align(input logic [63:0] data, input logic [2:0] bc);
        return data << (7'd64 - frame_bits(bc));
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with level, rise and fall outputs
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic sys_clk,
    input  logic rst_b,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_hist <= RESET_VAL;
        end else begin
            r_sync <= SYNC_STAGES'({r_sync, i_pin});
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_hist;
    assign o_fall  = ~o_level & r_hist;

endmodule

// File: rtl/spi_slave_ctrl.sv
// rtl/spi_slave_ctrl.sv - SPI mode-0 slave with register-side frame interface
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        sys_clk,
    input  logic        rst_b,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    input  logic        reg_ctrl_en,
    input  logic [2:0]  reg_ctrl_bc,
    input  logic [63:0] reg_ctrl_tx_data,
    output logic [63:0] ctrl_reg_rx_data,
    output logic        ctrl_reg_rd_en,
    output logic        ctrl_reg_busy,
    output logic        ctrl_reg_abort
);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .sys_clk(sys_clk), .rst_b(rst_b), .i_pin(spi_sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .sys_clk(sys_clk), .rst_b(rst_b), .i_pin(spi_cs_n),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .sys_clk(sys_clk), .rst_b(rst_b), .i_pin(spi_mosi),
        .o_level(w_mosi_lvl), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall));

    spi_state_e  r_state, w_next;
    logic [2:0]  r_frame_len;
    logic [63:0] r_tx_sh, r_rx_sh, r_rx_data;
    logic [6:0]  r_bit_cnt;
    logic        r_rd_en, r_abort;
    logic        w_load, w_sample, w_shift, w_finish, w_abort;
    logic [63:0] w_rx_next;

    assign w_rx_next = {r_rx_sh[62:0], w_mosi_lvl};

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_sample = 1'b0;
        w_shift  = 1'b0;
        w_finish = 1'b0;
        w_abort  = 1'b0;
        if (!reg_ctrl_en) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        w_next = ST_SHIFT;
                        w_load = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_cs_rise) begin
                        w_next  = ST_IDLE;
                        w_abort = (r_bit_cnt != 7'd0);
                    end else begin
                        if (w_sclk_rise) begin
                            w_sample = 1'b1;
                            if (r_bit_cnt + 7'd1 == frame_bits(r_frame_len)) begin
                                w_next   = ST_DONE;
                                w_finish = 1'b1;
                            end
                        end
                        // The trailing fall of the previous frame must not eat the freshly loaded MSB.
                        if (w_sclk_fall && r_bit_cnt != 7'd0) begin
                            w_shift = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    w_load = 1'b1;
                    w_next = w_cs_lvl ? ST_IDLE : ST_SHIFT;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state     <= ST_IDLE;
            r_frame_len <= 3'd0;
            r_tx_sh     <= 64'd0;
            r_rx_sh     <= 64'd0;
            r_rx_data   <= 64'd0;
            r_bit_cnt   <= 7'd0;
            r_rd_en     <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rd_en <= w_finish;
            r_abort <= w_abort;
            if (w_load) begin
                r_frame_len <= reg_ctrl_bc;
                r_tx_sh     <= tx_align(reg_ctrl_tx_data, reg_ctrl_bc);
                r_rx_sh     <= 64'd0;
                r_bit_cnt   <= 7'd0;
            end
            if (w_sample) begin
                r_rx_sh   <= w_rx_next;
                r_bit_cnt <= r_bit_cnt + 7'd1;
            end
            if (w_shift) begin
                r_tx_sh <= {r_tx_sh[62:0], 1'b0};
            end
            if (w_finish) begin
                r_rx_data <= w_rx_next;
            end
        end
    end

    assign spi_miso_oe      = (r_state != ST_IDLE) && !w_cs_lvl;
    assign spi_miso         = spi_miso_oe & r_tx_sh[63];
    assign ctrl_reg_rx_data = r_rx_data;
    assign ctrl_reg_rd_en   = r_rd_en;
    assign ctrl_reg_abort   = r_abort;
    assign ctrl_reg_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb/tb_spi_slave_ctrl.sv - directed and randomized bench for spi_slave_ctrl
module tb_spi_slave_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe;
    logic        reg_ctrl_en = 1'b0;
    logic [2:0]  reg_ctrl_bc = 3'd0;
    logic [63:0] reg_ctrl_tx_data = 64'd0;
    logic [63:0] ctrl_reg_rx_data;
    logic        ctrl_reg_rd_en, ctrl_reg_busy, ctrl_reg_abort;

    spi_slave_ctrl #(.SYNC_STAGES(2)) dut (
        .sys_clk(sys_clk), .rst_b(rst_b),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .reg_ctrl_en(reg_ctrl_en), .reg_ctrl_bc(reg_ctrl_bc),
        .reg_ctrl_tx_data(reg_ctrl_tx_data),
        .ctrl_reg_rx_data(ctrl_reg_rx_data), .ctrl_reg_rd_en(ctrl_reg_rd_en),
        .ctrl_reg_busy(ctrl_reg_busy), .ctrl_reg_abort(ctrl_reg_abort));

    always #5 sys_clk = ~sys_clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          rd_cnt = 0;
    int          abort_cnt = 0;
    int          busy_low = 0;
    logic [63:0] rx_q[$];
    logic [63:0] miso_acc;

    always @(negedge sys_clk) begin
        if (ctrl_reg_rd_en) begin
            rd_cnt++;
            rx_q.push_back(ctrl_reg_rx_data);
        end
        if (ctrl_reg_abort) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(negedge sys_clk);
    endtask

    // Master side of mode 0: MISO sampled just before each rising SCLK.
    task automatic send_bits(input int n, input logic [63:0] w);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = w[i];
            half();
            miso_acc = {miso_acc[62:0], spi_miso};
            if (!ctrl_reg_busy) busy_low++;
            spi_sclk = 1'b1;
            half();
            spi_sclk = 1'b0;
        end
    endtask

    function automatic logic [63:0] mask_n(input int n);
        logic [63:0] ones;
        ones = '1;
        return (n >= 64) ? ones : ((64'd1 << n) - 64'd1);
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_miso"}, {63'd0, spi_miso}, 64'd0);
        chk({tag, "_oe"}, {63'd0, spi_miso_oe}, 64'd0);
        chk({tag, "_rx"}, ctrl_reg_rx_data, 64'd0);
        chk({tag, "_rd"}, {63'd0, ctrl_reg_rd_en}, 64'd0);
        chk({tag, "_busy"}, {63'd0, ctrl_reg_busy}, 64'd0);
        chk({tag, "_abort"}, {63'd0, ctrl_reg_abort}, 64'd0);
    endtask

    initial begin
        logic [63:0] tx_w, mo_w, m1, m2, exp_rx;
        int          n, bc, rd0, ab0;

        repeat (3) @(negedge sys_clk);
        chk_reset_outputs("reset");
        rst_b = 1'b1;
        reg_ctrl_en = 1'b1;
        repeat (3) @(negedge sys_clk);

        // Single 8-bit frame
        reg_ctrl_bc = 3'd0;
        reg_ctrl_tx_data = 64'hA5;
        miso_acc = '0;
        spi_cs_n = 1'b0;
        send_bits(8, 64'h3C);
        half();
        spi_cs_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        chk("f8_miso", miso_acc, 64'hA5);
        chk("f8_rd_cnt", 64'(rd_cnt), 64'd1);
        chk("f8_rx_at_pulse", rx_q[0], 64'h3C);
        chk("f8_rx_reg", ctrl_reg_rx_data, 64'h3C);
        chk("f8_abort_cnt", 64'(abort_cnt), 64'd0);
        chk("f8_idle_busy", {63'd0, ctrl_reg_busy}, 64'd0);

        // Full 64-bit frame
        reg_ctrl_bc = 3'd7;
        reg_ctrl_tx_data = 64'h0123_4567_89AB_CDEF;
        miso_acc = '0;
        busy_low = 0;
        spi_cs_n = 1'b0;
        half();
        send_bits(64, 64'hFEDC_BA98_7654_3210);
        half();
        spi_cs_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        chk("f64_miso", miso_acc, 64'h0123_4567_89AB_CDEF);
        chk("f64_rx", ctrl_reg_rx_data, 64'hFEDC_BA98_7654_3210);
        chk("f64_busy_low", 64'(busy_low), 64'd0);
        chk("f64_rd_cnt", 64'(rd_cnt), 64'd2);

        // Back-to-back 16-bit frames, response changed during the first frame
        reg_ctrl_bc = 3'd1;
        reg_ctrl_tx_data = 64'h1234;
        m1 = 64'h9A5C;
        m2 = 64'h0FF1;
        rx_q.delete();
        rd0 = rd_cnt;
        miso_acc = '0;
        spi_cs_n = 1'b0;
        send_bits(8, m1 >> 8);
        reg_ctrl_tx_data = 64'hBEEF;
        send_bits(8, m1 & 64'hFF);
        send_bits(16, m2);
        half();
        spi_cs_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        chk("b2b_rd_cnt", 64'(rd_cnt - rd0), 64'd2);
        chk("b2b_miso", miso_acc, 64'h1234_BEEF);
        chk("b2b_rx0", (rx_q.size() > 0) ? rx_q[0] : 64'hX, m1);
        chk("b2b_rx1", (rx_q.size() > 1) ? rx_q[1] : 64'hX, m2);

        // Abort after 13 of 32 bits
        reg_ctrl_bc = 3'd3;
        reg_ctrl_tx_data = {$urandom, $urandom};
        rd0 = rd_cnt;
        ab0 = abort_cnt;
        spi_cs_n = 1'b0;
        send_bits(13, 64'(32'($urandom)));
        half();
        spi_cs_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        chk("abort_cnt", 64'(abort_cnt - ab0), 64'd1);
        chk("abort_no_rd", 64'(rd_cnt - rd0), 64'd0);
        chk("abort_rx_kept", ctrl_reg_rx_data, m2);
        chk("abort_busy", {63'd0, ctrl_reg_busy}, 64'd0);
        chk("abort_oe", {63'd0, spi_miso_oe}, 64'd0);

        // CS toggle with no clocks is silent
        ab0 = abort_cnt;
        spi_cs_n = 1'b0;
        half();
        spi_cs_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        chk("silent_cs_abort", 64'(abort_cnt - ab0), 64'd0);

        // Enable drop, then reset, each mid-frame
        reg_ctrl_bc = 3'd0;
        rd0 = rd_cnt;
        ab0 = abort_cnt;
        spi_cs_n = 1'b0;
        send_bits(4, 64'hA);
        reg_ctrl_en = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("en_drop_busy", {63'd0, ctrl_reg_busy}, 64'd0);
        chk("en_drop_oe", {63'd0, spi_miso_oe}, 64'd0);
        spi_cs_n = 1'b1;
        half();
        reg_ctrl_en = 1'b1;
        spi_cs_n = 1'b0;
        send_bits(4, 64'h5);
        rst_b = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk_reset_outputs("mid_rst");
        spi_cs_n = 1'b1;
        @(negedge sys_clk);
        rst_b = 1'b1;
        repeat (8) @(negedge sys_clk);
        chk("rst_no_rd", 64'(rd_cnt - rd0), 64'd0);
        chk("rst_no_abort", 64'(abort_cnt - ab0), 64'd0);
        chk("rst_busy", {63'd0, ctrl_reg_busy}, 64'd0);
        chk("rst_rx", ctrl_reg_rx_data, 64'd0);

        // Randomized single frames with register inputs scrambled mid-frame
        for (int k = 0; k < 6; k++) begin
            bc = int'($urandom_range(0, 7));
            n = 8 * (bc + 1);
            tx_w = {$urandom, $urandom};
            mo_w = {$urandom, $urandom} & mask_n(n);
            reg_ctrl_bc = 3'(bc);
            reg_ctrl_tx_data = tx_w;
            rd0 = rd_cnt;
            rx_q.delete();
            miso_acc = '0;
            spi_cs_n = 1'b0;
            send_bits(1, mo_w >> (n - 1));
            reg_ctrl_tx_data = {$urandom, $urandom};
            reg_ctrl_bc = 3'($urandom_range(0, 7));
            send_bits(n - 1, mo_w);
            half();
            spi_cs_n = 1'b1;
            repeat (6) @(negedge sys_clk);
            exp_rx = mo_w;
            chk($sformatf("rand%0d_miso", k), miso_acc, tx_w & mask_n(n));
            chk($sformatf("rand%0d_rd", k), 64'(rd_cnt - rd0), 64'd1);
            chk($sformatf("rand%0d_rx", k), ctrl_reg_rx_data, exp_rx);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
